// File: rtl/dog_palette_pkg.sv
// Shared types and widths for the dog sprite palette arbiter.
// Holds index/colour widths, the RGB bundle and FSM state encoding.
package dog_palette_pkg;

    localparam int IDX_W   = 4;
    localparam int COLOR_W = 4;

    localparam logic [IDX_W-1:0] TRANSPARENT_IDX_DEF = 4'd1;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        OUT    = 2'd2
    } state_t;

endpackage

// File: rtl/dog_palette_arbiter_rr.sv
// Combinational round-robin picker: req/ptr/en in, gnt (one-hot)
// and gnt_idx out; search starts at ptr+1 and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);

    always_comb begin
        logic          found;
        logic [IW-1:0] k;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = IW'((int'(ptr) + i) % NUM_REQ);
            if (en && !found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = k;
            end
        end
    end

endmodule

// File: rtl/dog_palette_arbiter.sv
// Round-robin share of one palette lookup with a writable index remap.
// Ports: Clk/Reset, req_* handshake, remap_* write, pal_* lookup, out_* result.
module dog_palette_arbiter
    import dog_palette_pkg::*;
#(
    parameter int               NUM_REQ         = 4,
    parameter logic [IDX_W-1:0] TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
    localparam int              ID_W            = $clog2(NUM_REQ)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     remap_we,
    input  logic [IDX_W-1:0]         remap_addr,
    input  logic [IDX_W-1:0]         remap_data,
    output logic [IDX_W-1:0]         pal_index,
    input  logic [COLOR_W-1:0]       pal_red,
    input  logic [COLOR_W-1:0]       pal_green,
    input  logic [COLOR_W-1:0]       pal_blue,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_W-1:0]          out_id,
    output logic [COLOR_W-1:0]       out_red,
    output logic [COLOR_W-1:0]       out_green,
    output logic [COLOR_W-1:0]       out_blue,
    output logic                     out_transparent
);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   raw_idx;
    logic [IDX_W-1:0]   remap [2**IDX_W];
    rgb_t               pal_rgb;
    rgb_t               out_rgb;

    // Gating with Reset keeps a requester from seeing a handshake
    // on an edge that the reset will discard.
    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IW     (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (state == IDLE && !Reset),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    assign req_ready = gnt;

    // One-hot grant selects the raw index; no variable part-select.
    always_comb begin
        raw_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) raw_idx = req_index[i*IDX_W +: IDX_W];
        end
    end

    assign pal_rgb   = {pal_red, pal_green, pal_blue};
    assign out_red   = out_rgb.red;
    assign out_green = out_rgb.green;
    assign out_blue  = out_rgb.blue;

    // Grant reads before the write lands, so a same-cycle
    // write to the granted entry affects only later lookups.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < 2**IDX_W; k++) begin
                remap[k] <= IDX_W'(k);
            end
        end else if (remap_we) begin
            remap[remap_addr] <= remap_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            ptr             <= ID_W'(NUM_REQ - 1);
            pal_index       <= '0;
            out_id          <= '0;
            out_rgb         <= '0;
            out_valid       <= 1'b0;
            out_transparent <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        pal_index <= remap[raw_idx];
                        out_id    <= gnt_idx;
                        ptr       <= gnt_idx;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    out_rgb         <= pal_rgb;
                    out_transparent <= (pal_index == TRANSPARENT_IDX);
                    out_valid       <= 1'b1;
                    state           <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dog_palette_arbiter.sv
// Bench for dog_palette_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_dog_palette_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  req_valid;
    logic [15:0] req_index;
    logic [3:0]  req_ready;
    logic        remap_we;
    logic [3:0]  remap_addr;
    logic [3:0]  remap_data;
    logic [3:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [3:0]  out_red, out_green, out_blue;
    logic        out_transparent;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    dog_palette_arbiter dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .req_valid      (req_valid),
        .req_index      (req_index),
        .req_ready      (req_ready),
        .remap_we       (remap_we),
        .remap_addr     (remap_addr),
        .remap_data     (remap_data),
        .pal_index      (pal_index),
        .pal_red        (pal_red),
        .pal_green      (pal_green),
        .pal_blue       (pal_blue),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_id         (out_id),
        .out_red        (out_red),
        .out_green      (out_green),
        .out_blue       (out_blue),
        .out_transparent(out_transparent)
    );

    // External palette ROM model.
    function automatic logic [11:0] pal_of(input logic [3:0] i);
        case (i)
            4'd0:    pal_of = 12'h940;
            4'd1:    pal_of = 12'h6AF;
            4'd2:    pal_of = 12'h000;
            4'd3:    pal_of = 12'hFFF;
            4'd4:    pal_of = 12'h520;
            default: pal_of = {i, ~i, i ^ 4'h5};
        endcase
    endfunction

    assign {pal_red, pal_green, pal_blue} = pal_of(pal_index);

    task automatic next();
        @(negedge Clk);
    endtask

    task automatic set_idx(input int r, input logic [3:0] v);
        req_index = (req_index & ~(16'hF << (4 * r)))
                  | (16'(v) << (4 * r));
    endtask

    task automatic do_reset();
        next();
        Reset     = 1'b1;
        req_valid = '0;
        remap_we  = 1'b0;
        out_ready = 1'b1;
        next();
        next();
        Reset = 1'b0;
    endtask

    // Steps until out_valid, dropping requests after the grant edge.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            next();
            req_valid = '0;
            remap_we  = 1'b0;
            #1;
            cnt++;
        end while (!out_valid && cnt < 8);
    endtask

    task automatic test_reset();
        req_index  = '0;
        remap_addr = '0;
        remap_data = '0;
        do_reset();
        #1;
        n_checks++;
        if ({req_ready, pal_index, out_valid, out_id} !== 11'd0) begin
            $display("FAIL reset_ctl: rdy=%b pal=%h v=%b id=%0d need 0",
                     req_ready, pal_index, out_valid, out_id);
            n_fail++;
        end
        n_checks++;
        if ({out_red, out_green, out_blue, out_transparent} !== 13'd0)
        begin
            $display("FAIL reset_out: rgb=%h%h%h t=%b need 0",
                     out_red, out_green, out_blue, out_transparent);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        int c;
        next();
        set_idx(0, 4'd0);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL basic_grant: rdy=%b need 0001", req_ready);
            n_fail++;
        end
        wait_valid(c);
        n_checks++;
        if (c != 2) begin
            $display("FAIL basic_latency: %0d need 2", c);
            n_fail++;
        end
        n_checks++;
        if ({out_red, out_green, out_blue, out_id, out_transparent}
            !== {12'h940, 2'd0, 1'b0}) begin
            $display("FAIL basic_result: rgb=%h%h%h id=%0d t=%b need 940/0/0",
                     out_red, out_green, out_blue, out_id, out_transparent);
            n_fail++;
        end
        next();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_drop: out_valid=%b need 0", out_valid);
            n_fail++;
        end
    endtask

    task automatic test_remap();
        int c;
        next();
        remap_we   = 1'b1;
        remap_addr = 4'd0;
        remap_data = 4'd3;
        next();
        remap_addr = 4'd4;
        remap_data = 4'd1;
        next();
        remap_we = 1'b0;
        set_idx(2, 4'd0);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL remap_grant0: rdy=%b need 0100", req_ready);
            n_fail++;
        end
        wait_valid(c);
        n_checks++;
        if ({out_red, out_green, out_blue, out_id, out_transparent}
            !== {12'hFFF, 2'd2, 1'b0}) begin
            $display("FAIL remap_idx0: rgb=%h%h%h id=%0d t=%b need FFF/2/0",
                     out_red, out_green, out_blue, out_id, out_transparent);
            n_fail++;
        end
        next();
        set_idx(2, 4'd4);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL remap_grant4: rdy=%b need 0100", req_ready);
            n_fail++;
        end
        wait_valid(c);
        n_checks++;
        if ({out_red, out_green, out_blue, out_id, out_transparent}
            !== {12'h6AF, 2'd2, 1'b1}) begin
            $display("FAIL remap_idx4: rgb=%h%h%h id=%0d t=%b need 6AF/2/1",
                     out_red, out_green, out_blue, out_id, out_transparent);
            n_fail++;
        end
        next();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        next();
        req_index = 16'h3210;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            #1;
            exp = (k % 3 == 0) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
            n_checks++;
            if (req_ready !== exp) begin
                $display("FAIL rr_grant c%0d: rdy=%b need %b",
                         k, req_ready, exp);
                n_fail++;
            end
            n_checks++;
            if ($countones(req_ready) > 1) begin
                $display("FAIL rr_onehot c%0d: rdy=%b need <=1 hot",
                         k, req_ready);
                n_fail++;
            end
            if (k % 3 == 2) begin
                n_checks++;
                if (out_id !== 2'((k / 3) % 4)) begin
                    $display("FAIL rr_id c%0d: id=%0d need %0d",
                             k, out_id, (k / 3) % 4);
                    n_fail++;
                end
            end
            next();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int c;
        do_reset();
        next();
        set_idx(1, 4'd3);
        set_idx(2, 4'd4);
        req_valid = 4'b0010;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            $display("FAIL bp_grant: rdy=%b need 0010", req_ready);
            n_fail++;
        end
        wait_valid(c);
        n_checks++;
        if (c != 2) begin
            $display("FAIL bp_latency: %0d need 2", c);
            n_fail++;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            next();
            #1;
            n_checks++;
            if ({out_valid, out_id, out_red, out_green, out_blue,
                 out_transparent, req_ready}
                !== {1'b1, 2'd1, 12'hFFF, 1'b0, 4'b0000}) begin
                $display("FAIL bp_hold c%0d: v=%b id=%0d rgb=%h%h%h rdy=%b need 1/1/FFF/0000",
                         k, out_valid, out_id, out_red, out_green,
                         out_blue, req_ready);
                n_fail++;
            end
        end
        next();
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL bp_release: out_valid=%b need 1", out_valid);
            n_fail++;
        end
        next();
        #1;
        n_checks++;
        if ({out_valid, req_ready} !== 5'b0_0100) begin
            $display("FAIL bp_next: v=%b rdy=%b need 0/0100",
                     out_valid, req_ready);
            n_fail++;
        end
        wait_valid(c);
        n_checks++;
        if ({out_red, out_green, out_blue, out_id} !== {12'h520, 2'd2})
        begin
            $display("FAIL bp_second: rgb=%h%h%h id=%0d need 520/2",
                     out_red, out_green, out_blue, out_id);
            n_fail++;
        end
        next();
    endtask

    task automatic test_collision();
        int c;
        do_reset();
        next();
        set_idx(0, 4'd2);
        req_valid  = 4'b0001;
        out_ready  = 1'b1;
        remap_we   = 1'b1;
        remap_addr = 4'd2;
        remap_data = 4'd4;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL coll_grant: rdy=%b need 0001", req_ready);
            n_fail++;
        end
        wait_valid(c);
        n_checks++;
        if ({out_red, out_green, out_blue} !== 12'h000) begin
            $display("FAIL coll_old: rgb=%h%h%h need 000",
                     out_red, out_green, out_blue);
            n_fail++;
        end
        next();
        req_valid = 4'b0001;
        #1;
        wait_valid(c);
        n_checks++;
        if ({out_red, out_green, out_blue} !== 12'h520) begin
            $display("FAIL coll_new: rgb=%h%h%h need 520",
                     out_red, out_green, out_blue);
            n_fail++;
        end
        next();
    endtask

    task automatic test_reset_midflight();
        int c;
        next();
        remap_we   = 1'b1;
        remap_addr = 4'd0;
        remap_data = 4'd3;
        next();
        remap_we = 1'b0;
        set_idx(0, 4'd0);
        set_idx(3, 4'd0);
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL mid_grant: rdy=%b need 1000", req_ready);
            n_fail++;
        end
        next();
        req_valid = '0;
        Reset     = 1'b1;
        next();
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, pal_index, out_valid, out_id, out_red,
             out_green, out_blue, out_transparent} !== 24'd0) begin
            $display("FAIL mid_reset: rdy=%b pal=%h v=%b id=%0d rgb=%h%h%h t=%b need 0",
                     req_ready, pal_index, out_valid, out_id, out_red,
                     out_green, out_blue, out_transparent);
            n_fail++;
        end
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL mid_prio: rdy=%b need 0001", req_ready);
            n_fail++;
        end
        wait_valid(c);
        n_checks++;
        if ({out_red, out_green, out_blue, out_id} !== {12'h940, 2'd0})
        begin
            $display("FAIL mid_ident: rgb=%h%h%h id=%0d need 940/0",
                     out_red, out_green, out_blue, out_id);
            n_fail++;
        end
        next();
    endtask

    // Transaction model: a grant goes to the first valid requester after
    // the last winner, its result shows up two cycles later and is held
    // until taken; new grants only while nothing is in flight.
    task automatic test_random();
        logic [3:0]  remap_m [16];
        logic [3:0]  exp_rdy;
        logic [3:0]  m_pidx;
        logic [15:0] sh;
        int          ptr_m, stage, m_id, g, j;
        do_reset();
        for (int k = 0; k < 16; k++) remap_m[k] = 4'(k);
        ptr_m  = 3;
        stage  = 0;
        m_id   = 0;
        m_pidx = 4'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            next();
            req_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            req_index  = 16'($urandom);
            out_ready  = ($urandom_range(0, 9) < 7);
            remap_we   = ($urandom_range(0, 9) == 0);
            remap_addr = 4'($urandom_range(0, 15));
            remap_data = 4'($urandom_range(0, 15));
            #1;
            g = -1;
            if (stage == 0) begin
                for (int i = 1; i <= 4; i++) begin
                    j = (ptr_m + i) % 4;
                    if (g < 0 && req_valid[2'(j)]) g = j;
                end
            end
            exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            n_checks++;
            if (req_ready !== exp_rdy) begin
                $display("FAIL rnd_rdy c%0d: rdy=%b need %b",
                         cyc, req_ready, exp_rdy);
                n_fail++;
            end
            n_checks++;
            if (out_valid !== (stage == 2)) begin
                $display("FAIL rnd_valid c%0d: v=%b need %b",
                         cyc, out_valid, stage == 2);
                n_fail++;
            end
            n_checks++;
            if (pal_index !== m_pidx) begin
                $display("FAIL rnd_pal c%0d: pal=%h need %h",
                         cyc, pal_index, m_pidx);
                n_fail++;
            end
            if (stage == 2) begin
                n_checks++;
                if ({out_id, out_red, out_green, out_blue, out_transparent}
                    !== {2'(m_id), pal_of(m_pidx), m_pidx == 4'd1}) begin
                    $display("FAIL rnd_out c%0d: id=%0d rgb=%h%h%h t=%b need %0d/%h/%b",
                             cyc, out_id, out_red, out_green, out_blue,
                             out_transparent, m_id, pal_of(m_pidx),
                             m_pidx == 4'd1);
                    n_fail++;
                end
            end
            case (stage)
                0: if (g >= 0) begin
                    sh     = req_index >> (4 * g);
                    m_pidx = remap_m[sh[3:0]];
                    m_id   = g;
                    ptr_m  = g;
                    stage  = 1;
                end
                1: stage = 2;
                default: if (out_ready) stage = 0;
            endcase
            if (remap_we) remap_m[remap_addr] = remap_data;
        end
        next();
        req_valid = '0;
        remap_we  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset      = 1'b1;
        req_valid  = '0;
        req_index  = '0;
        remap_we   = 1'b0;
        remap_addr = '0;
        remap_data = '0;
        out_ready  = 1'b1;
        test_reset();
        test_basic();
        test_remap();
        test_round_robin();
        test_backpressure();
        test_collision();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
